boolean_tt_checker: RTL and testbench

Hardware-side stimulus driver and response checker for the 3-input/1-output Boolean combinational blocks in this codebase. It drives A, B and C through all 8 input combinations in ascending order, waits a fixed settle time, and samples F. Each sample is compared against a parameterised expected truth table. Pass/fail results and the first failing vector are reported. It sits beside a Boolean DUT on-chip, so a truth-table check runs without a simulator testbench.

---
 rtl/boolean_tt_checker_if.sv | 29 ++
 rtl/boolean_tt_checker.sv | 147 ++++++++++++++
 tb/tb_boolean_tt_checker.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/boolean_tt_checker_if.sv
`default_nettype none
// ==========================================================================
// boolean_tt_checker_if : stimulus/response and result bundle of the checker
// Rev 1.0
// ==========================================================================
interface boolean_tt_checker_if;
   logic       start;
   logic       A;
   logic       B;
   logic       C;
   logic       F;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] fail_count;
   logic       fail_valid;
   logic [2:0] first_fail_vec;

   // master = the checker, slave = whoever starts it and owns the Boolean block
   modport master (
      input  start, F,
      output A, B, C, busy, done, pass, fail_count, fail_valid, first_fail_vec
   );
   modport slave (
      output start, F,
      input  A, B, C, busy, done, pass, fail_count, fail_valid, first_fail_vec
   );
endinterface
`default_nettype wire

// File: rtl/boolean_tt_checker.sv
`default_nettype none
// ==========================================================================
// boolean_tt_checker : sweeps {A,B,C} 0..7, samples F after a settle time,
// compares against EXPECTED_TT. Macro BOOLEAN_TT_STOP_ON_FAIL_EN stops at the
// first mismatch. Rev 1.0
// ==========================================================================
module boolean_tt_checker #(
   parameter logic [7:0] EXPECTED_TT   = 8'h1E,
   parameter int         SETTLE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   boolean_tt_checker_if.master bus
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
`ifdef BOOLEAN_TT_STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRIVE  = 3'd1,
      SETTLE = 3'd2,
      CHECK  = 3'd3,
      FINISH = 3'd4
   } state_t;

   state_t     state, state_next;
   logic [2:0] vec, vec_next;
   logic [3:0] settle_cnt, settle_cnt_next;
   logic [2:0] abc, abc_next;
   logic       busy, busy_next;
   logic       done, done_next;
   logic       pass, pass_next;
   logic [3:0] fail_count, fail_count_next;
   logic       fail_valid, fail_valid_next;
   logic [2:0] first_fail_vec, first_fail_vec_next;
   logic       mismatch;

   assign mismatch = (bus.F != EXPECTED_TT[vec]);

   always_comb begin
      state_next          = state;
      vec_next            = vec;
      settle_cnt_next     = settle_cnt;
      abc_next            = abc;
      busy_next           = busy;
      done_next           = 1'b0;
      pass_next           = pass;
      fail_count_next     = fail_count;
      fail_valid_next     = fail_valid;
      first_fail_vec_next = first_fail_vec;

      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next          = DRIVE;
               busy_next           = 1'b1;
               vec_next            = 3'd0;
               pass_next           = 1'b0;
               fail_count_next     = 4'd0;
               fail_valid_next     = 1'b0;
               first_fail_vec_next = 3'd0;
            end
         end
         DRIVE: begin
            abc_next        = vec;
            busy_next       = 1'b1;
            settle_cnt_next = SETTLE_LOAD;
            state_next      = SETTLE;
         end
         SETTLE: begin
            if (settle_cnt == 4'd0) begin
               state_next = CHECK;
            end else begin
               settle_cnt_next = settle_cnt - 4'd1;
            end
         end
         CHECK: begin
            if (mismatch) begin
               fail_count_next = fail_count + 4'd1;
               if (!fail_valid) begin
                  fail_valid_next     = 1'b1;
                  first_fail_vec_next = vec;
               end
            end
            // done/pass are registered, so they are produced on the edge into FINISH
            if (vec == 3'd7 || (STOP_ON_FAIL && mismatch)) begin
               state_next = FINISH;
               done_next  = 1'b1;
               busy_next  = 1'b0;
               pass_next  = (fail_count_next == 4'd0);
            end else begin
               vec_next   = vec + 3'd1;
               state_next = DRIVE;
            end
         end
         FINISH: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         vec            <= 3'd0;
         settle_cnt     <= 4'd0;
         abc            <= 3'd0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_count     <= 4'd0;
         fail_valid     <= 1'b0;
         first_fail_vec <= 3'd0;
      end else begin
         state          <= state_next;
         vec            <= vec_next;
         settle_cnt     <= settle_cnt_next;
         abc            <= abc_next;
         busy           <= busy_next;
         done           <= done_next;
         pass           <= pass_next;
         fail_count     <= fail_count_next;
         fail_valid     <= fail_valid_next;
         first_fail_vec <= first_fail_vec_next;
      end
   end

   assign bus.A              = abc[2];
   assign bus.B              = abc[1];
   assign bus.C              = abc[0];
   assign bus.busy           = busy;
   assign bus.done           = done;
   assign bus.pass           = pass;
   assign bus.fail_count     = fail_count;
   assign bus.fail_valid     = fail_valid;
   assign bus.first_fail_vec = first_fail_vec;

endmodule
`default_nettype wire

// File: tb/tb_boolean_tt_checker.sv
`default_nettype none
// ==========================================================================
// tb_boolean_tt_checker : directed checks of the truth-table checker, with a
// combinational model DUT (dut0) and a 3-cycle-latency model DUT (dut1).
// Rev 1.0
// ==========================================================================
module tb_boolean_tt_checker;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tt = 8'h1E;
   logic [2:0] pipe;
   int         mode = 0;   // 0 match, 1 single fault at 3'b110, 2 stuck-at-0
   int         passed = 0;
   int         total = 0;

   boolean_tt_checker_if if0 ();
   boolean_tt_checker_if if1 ();

   boolean_tt_checker #(.EXPECTED_TT(8'h1E), .SETTLE_CYCLES(2)) dut0 (
      .clk(clk), .reset(reset), .bus(if0)
   );
   boolean_tt_checker #(.EXPECTED_TT(8'h1E), .SETTLE_CYCLES(3)) dut1 (
      .clk(clk), .reset(reset), .bus(if1)
   );

   always #5 clk = ~clk;

   always_comb begin
      case (mode)
         1:       if0.F = ({if0.A, if0.B, if0.C} == 3'b110) ? 1'b1 : tt[{if0.A, if0.B, if0.C}];
         2:       if0.F = 1'b0;
         default: if0.F = tt[{if0.A, if0.B, if0.C}];
      endcase
   end

   always @(posedge clk) pipe <= {pipe[1:0], tt[{if1.A, if1.B, if1.C}]};
   assign if1.F = pipe[2];

   // Pulse start on one checker and return the clock index (start edge = 1) of done.
   task automatic run_sweep(input bit sel, output int done_at);
      done_at = -1;
      if (sel) if1.start = 1'b1; else if0.start = 1'b1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk); #1;
         if (n == 1) begin
            if0.start = 1'b0;
            if1.start = 1'b0;
         end
         if ((sel ? if1.done : if0.done) === 1'b1) begin
            done_at = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      total++;
      if ({if0.A, if0.B, if0.C, if0.busy, if0.done, if0.pass, if0.fail_count,
           if0.fail_valid, if0.first_fail_vec} !== 14'd0)
         $display("FAIL reset_dut0 got %b exp 0", {if0.A, if0.B, if0.C, if0.busy,
                  if0.done, if0.pass, if0.fail_count, if0.fail_valid, if0.first_fail_vec});
      else passed++;
      total++;
      if ({if1.A, if1.B, if1.C, if1.busy, if1.done, if1.pass, if1.fail_count,
           if1.fail_valid, if1.first_fail_vec} !== 14'd0)
         $display("FAIL reset_dut1 got %b exp 0", {if1.A, if1.B, if1.C, if1.busy,
                  if1.done, if1.pass, if1.fail_count, if1.fail_valid, if1.first_fail_vec});
      else passed++;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_match;
      int d;
      mode = 0;
      run_sweep(1'b0, d);
      total++; if (d !== 33) $display("FAIL match_done_at got %0d exp 33", d); else passed++;
      total++; if (if0.busy !== 1'b0) $display("FAIL match_busy got %b exp 0", if0.busy); else passed++;
      total++; if (if0.pass !== 1'b1) $display("FAIL match_pass got %b exp 1", if0.pass); else passed++;
      total++; if (if0.fail_count !== 4'd0) $display("FAIL match_fail_count got %0d exp 0", if0.fail_count); else passed++;
      total++; if (if0.fail_valid !== 1'b0) $display("FAIL match_fail_valid got %b exp 0", if0.fail_valid); else passed++;
      total++; if ({if0.A, if0.B, if0.C} !== 3'b111) $display("FAIL match_abc got %b exp 111", {if0.A, if0.B, if0.C}); else passed++;
      @(posedge clk); #1;
      total++;
      if (if0.done !== 1'b0 || if0.pass !== 1'b1)
         $display("FAIL match_hold got done=%b pass=%b exp done=0 pass=1", if0.done, if0.pass);
      else passed++;
   endtask

   task automatic test_single_fault;
      int d;
      mode = 1;
      run_sweep(1'b0, d);
      total++; if (d !== 33) $display("FAIL single_done_at got %0d exp 33", d); else passed++;
      total++; if (if0.pass !== 1'b0) $display("FAIL single_pass got %b exp 0", if0.pass); else passed++;
      total++; if (if0.fail_count !== 4'd1) $display("FAIL single_fail_count got %0d exp 1", if0.fail_count); else passed++;
      total++; if (if0.fail_valid !== 1'b1) $display("FAIL single_fail_valid got %b exp 1", if0.fail_valid); else passed++;
      total++; if (if0.first_fail_vec !== 3'b110) $display("FAIL single_first_vec got %b exp 110", if0.first_fail_vec); else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_stuck_at;
      int d;
      mode = 2;
      run_sweep(1'b0, d);
`ifdef BOOLEAN_TT_STOP_ON_FAIL_EN
      total++; if (d !== 9) $display("FAIL stuck_done_at got %0d exp 9", d); else passed++;
      total++; if (if0.fail_count !== 4'd1) $display("FAIL stuck_fail_count got %0d exp 1", if0.fail_count); else passed++;
      total++; if ({if0.A, if0.B, if0.C} !== 3'b001) $display("FAIL stuck_abc got %b exp 001", {if0.A, if0.B, if0.C}); else passed++;
`else
      total++; if (d !== 33) $display("FAIL stuck_done_at got %0d exp 33", d); else passed++;
      total++; if (if0.fail_count !== 4'd4) $display("FAIL stuck_fail_count got %0d exp 4", if0.fail_count); else passed++;
      total++; if ({if0.A, if0.B, if0.C} !== 3'b111) $display("FAIL stuck_abc got %b exp 111", {if0.A, if0.B, if0.C}); else passed++;
`endif
      total++; if (if0.first_fail_vec !== 3'b001) $display("FAIL stuck_first_vec got %b exp 001", if0.first_fail_vec); else passed++;
      total++; if (if0.pass !== 1'b0) $display("FAIL stuck_pass got %b exp 0", if0.pass); else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_settle_timing;
      int d;
      run_sweep(1'b1, d);
      total++; if (d !== 41) $display("FAIL settle_done_at got %0d exp 41", d); else passed++;
      total++; if (if1.pass !== 1'b1) $display("FAIL settle_pass got %b exp 1", if1.pass); else passed++;
      total++; if (if1.fail_count !== 4'd0) $display("FAIL settle_fail_count got %0d exp 0", if1.fail_count); else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_restart_ignored;
      int d;
      d = -1;
      mode = 0;
      if0.start = 1'b1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk); #1;
         if (n == 1) if0.start = 1'b0;
         if (n == 9) if0.start = 1'b1;
         if (n == 10) begin
            if0.start = 1'b0;
            total++; if (if0.busy !== 1'b1) $display("FAIL restart_busy got %b exp 1", if0.busy); else passed++;
         end
         if (if0.done === 1'b1) begin
            d = n;
            break;
         end
      end
      total++; if (d !== 33) $display("FAIL restart_done_at got %0d exp 33", d); else passed++;
      total++; if (if0.pass !== 1'b1) $display("FAIL restart_pass got %b exp 1", if0.pass); else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_sweep;
      bit seen;
      seen = 1'b0;
      mode = 1;
      if0.start = 1'b1;
      for (int n = 1; n <= 11; n++) begin
         @(posedge clk); #1;
         if (n == 1) if0.start = 1'b0;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({if0.A, if0.B, if0.C, if0.busy, if0.done, if0.pass, if0.fail_count,
           if0.fail_valid, if0.first_fail_vec} !== 14'd0)
         $display("FAIL midreset_outputs got %b exp 0", {if0.A, if0.B, if0.C, if0.busy,
                  if0.done, if0.pass, if0.fail_count, if0.fail_valid, if0.first_fail_vec});
      else passed++;
      reset = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(posedge clk); #1;
         if (if0.done !== 1'b0 || if0.busy !== 1'b0) seen = 1'b1;
      end
      total++; if (seen) $display("FAIL midreset_no_done got activity=1 exp 0"); else passed++;
   endtask

   task automatic test_back_to_back;
      int d;
      mode = 2;
      run_sweep(1'b0, d);
      total++; if (if0.pass !== 1'b0) $display("FAIL b2b_first_pass got %b exp 0", if0.pass); else passed++;
      // start raised in the FINISH cycle must not launch a sweep
      if0.start = 1'b1;
      @(posedge clk); #1;
      total++; if (if0.busy !== 1'b0) $display("FAIL b2b_finish_start got busy=%b exp 0", if0.busy); else passed++;
      mode = 0;
      @(posedge clk); #1;
      if0.start = 1'b0;
      total++; if (if0.busy !== 1'b1) $display("FAIL b2b_accept_busy got %b exp 1", if0.busy); else passed++;
      total++;
      if ({if0.pass, if0.fail_count, if0.fail_valid, if0.first_fail_vec} !== 9'd0)
         $display("FAIL b2b_cleared got %b exp 0", {if0.pass, if0.fail_count, if0.fail_valid, if0.first_fail_vec});
      else passed++;
      d = -1;
      for (int n = 2; n <= 200; n++) begin
         @(posedge clk); #1;
         if (if0.done === 1'b1) begin
            d = n;
            break;
         end
      end
      total++; if (d !== 33) $display("FAIL b2b_done_at got %0d exp 33", d); else passed++;
      total++; if (if0.pass !== 1'b1) $display("FAIL b2b_pass got %b exp 1", if0.pass); else passed++;
      total++; if (if0.fail_count !== 4'd0) $display("FAIL b2b_fail_count got %0d exp 0", if0.fail_count); else passed++;
      @(posedge clk); #1;
   endtask

   initial begin
      if0.start = 1'b0;
      if1.start = 1'b0;
      test_reset();
      test_match();
      test_single_fault();
      test_stuck_at();
      test_settle_timing();
      test_restart_ignored();
      test_reset_mid_sweep();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
